multi_channel_clock_generator: RTL and testbench



---
 rtl/multi_channel_clock_generator.sv | 142 ++++++++++++++
 tb/tb_multi_channel_clock_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clock_generator.sv
// Reloadable tick generator (run/halt/single-step) driving N derived-clock channels.
// fpgaTick is registered one cycle after counter==0 or a step edge; no backpressure.
module multi_channel_clock_generator #(
    parameter int NR_OF_CHANNELS  = 4,
    parameter int NR_OF_BITS      = 31,
    parameter int RELOAD_VALUE    = 2147483647,
    parameter int CNT_BITS        = 8,
    parameter int INIT_HIGH_TICKS = 1,
    parameter int INIT_LOW_TICKS  = 1
) (
    input  logic                                                         fpgaGlobalClock,
    input  logic                                                         fpgaGlobalResetN,
    input  logic                                                         run,
    input  logic                                                         step,
    input  logic [NR_OF_BITS-1:0]                                        tickReload,
    input  logic                                                         cfgWrite,
    input  logic [((NR_OF_CHANNELS > 1) ? $clog2(NR_OF_CHANNELS) : 1)-1:0] cfgChannel,
    input  logic [CNT_BITS-1:0]                                          cfgHighTicks,
    input  logic [CNT_BITS-1:0]                                          cfgLowTicks,
    output logic                                                         fpgaTick,
    output logic [5*NR_OF_CHANNELS-1:0]                                  clockBus,
    output logic [NR_OF_CHANNELS-1:0]                                    cfgPending
);

    localparam logic ST_LOW  = 1'b0;
    localparam logic ST_HIGH = 1'b1;

    logic [NR_OF_BITS-1:0] cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    logic                  step_q;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (run) begin
            if (cnt_q == '0) begin
                cnt_d  = tickReload;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q - NR_OF_BITS'(1);
            end
        end else if (step && !step_q) begin
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge fpgaGlobalClock or negedge fpgaGlobalResetN) begin
        if (!fpgaGlobalResetN) begin
            cnt_q  <= NR_OF_BITS'(RELOAD_VALUE);
            tick_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            step_q <= step;
        end
    end

    assign fpgaTick = tick_q;

    // A zero count would stall the phase counter, so writes are clamped to one tick.
    logic [CNT_BITS-1:0] cfg_hi, cfg_lo;
    assign cfg_hi = (cfgHighTicks == '0) ? CNT_BITS'(1) : cfgHighTicks;
    assign cfg_lo = (cfgLowTicks  == '0) ? CNT_BITS'(1) : cfgLowTicks;

    for (genvar c = 0; c < NR_OF_CHANNELS; c++) begin : g_ch
        logic                state_q, state_d;
        logic [CNT_BITS-1:0] phase_q, phase_d;
        logic [CNT_BITS-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
        logic [CNT_BITS-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
        logic                pend_q, pend_d;
        logic                last_tick;
        logic                wr_sel;

        assign last_tick = (phase_q == CNT_BITS'(1));
        assign wr_sel    = cfgWrite && (int'(cfgChannel) == c);

        always_comb begin
            state_d  = state_q;
            phase_d  = phase_q;
            act_hi_d = act_hi_q;
            act_lo_d = act_lo_q;
            sh_hi_d  = sh_hi_q;
            sh_lo_d  = sh_lo_q;
            pend_d   = pend_q;
            if (tick_q) begin
                if (last_tick) begin
                    if (state_q == ST_HIGH) begin
                        state_d = ST_LOW;
                        phase_d = act_lo_q;
                    end else begin
                        state_d = ST_HIGH;
                        if (pend_q) begin
                            act_hi_d = sh_hi_q;
                            act_lo_d = sh_lo_q;
                            phase_d  = sh_hi_q;
                            pend_d   = 1'b0;
                        end else begin
                            phase_d = act_hi_q;
                        end
                    end
                end else if (phase_q > CNT_BITS'(1)) begin
                    phase_d = phase_q - CNT_BITS'(1);
                end
            end
            // A write coinciding with the transfer lands after it and keeps pending set.
            if (wr_sel) begin
                sh_hi_d = cfg_hi;
                sh_lo_d = cfg_lo;
                pend_d  = 1'b1;
            end
        end

        always_ff @(posedge fpgaGlobalClock or negedge fpgaGlobalResetN) begin
            if (!fpgaGlobalResetN) begin
                state_q  <= ST_HIGH;
                phase_q  <= CNT_BITS'(INIT_HIGH_TICKS);
                act_hi_q <= CNT_BITS'(INIT_HIGH_TICKS);
                act_lo_q <= CNT_BITS'(INIT_LOW_TICKS);
                sh_hi_q  <= CNT_BITS'(INIT_HIGH_TICKS);
                sh_lo_q  <= CNT_BITS'(INIT_LOW_TICKS);
                pend_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                phase_q  <= phase_d;
                act_hi_q <= act_hi_d;
                act_lo_q <= act_lo_d;
                sh_hi_q  <= sh_hi_d;
                sh_lo_q  <= sh_lo_d;
                pend_q   <= pend_d;
            end
        end

        assign clockBus[5*c +: 5] = {tick_q,
                                     tick_q & (state_q == ST_HIGH) & last_tick,
                                     tick_q & (state_q == ST_LOW) & last_tick,
                                     ~state_q,
                                     state_q};
        assign cfgPending[c] = pend_q;
    end

endmodule

// File: tb/tb_multi_channel_clock_generator.sv
// Directed bench for multi_channel_clock_generator: vector table plus hand-written sequences.
module tb_multi_channel_clock_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [30:0] tick_reload = 31'd3;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic [7:0]  cfg_hi = 8'd0;
    logic [7:0]  cfg_lo = 8'd0;
    logic        tick;
    logic [19:0] bus;
    logic [3:0]  pend;

    logic        wr3 = 1'b0;
    logic [1:0]  ch3 = 2'd0;
    logic        tick3;
    logic [14:0] bus3;
    logic [2:0]  pend3;

    always #5 clk = ~clk;

    multi_channel_clock_generator #(
        .NR_OF_CHANNELS(4), .NR_OF_BITS(31), .RELOAD_VALUE(3),
        .CNT_BITS(8), .INIT_HIGH_TICKS(1), .INIT_LOW_TICKS(1)
    ) u_dut (
        .fpgaGlobalClock(clk), .fpgaGlobalResetN(rst_n), .run(run), .step(step),
        .tickReload(tick_reload), .cfgWrite(cfg_wr), .cfgChannel(cfg_ch),
        .cfgHighTicks(cfg_hi), .cfgLowTicks(cfg_lo),
        .fpgaTick(tick), .clockBus(bus), .cfgPending(pend)
    );

    multi_channel_clock_generator #(
        .NR_OF_CHANNELS(3), .NR_OF_BITS(31), .RELOAD_VALUE(3),
        .CNT_BITS(8), .INIT_HIGH_TICKS(1), .INIT_LOW_TICKS(1)
    ) u_dut3 (
        .fpgaGlobalClock(clk), .fpgaGlobalResetN(rst_n), .run(1'b0), .step(1'b0),
        .tickReload(31'd3), .cfgWrite(wr3), .cfgChannel(ch3),
        .cfgHighTicks(8'd5), .cfgLowTicks(8'd5),
        .fpgaTick(tick3), .clockBus(bus3), .cfgPending(pend3)
    );

    typedef struct {
        logic       wr;
        logic       run;
        logic       exp_tick;
        logic [4:0] exp_bus0;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vt [17];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_ticks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_cycle(input logic [1:0] ch, input logic [7:0] hi, input logic [7:0] lo);
        cfg_wr = 1'b1;
        cfg_ch = ch;
        cfg_hi = hi;
        cfg_lo = lo;
        cyc();
        cfg_wr = 1'b0;
    endtask

    function automatic logic lvl(input int c);
        return bus[5*c];
    endfunction

    initial begin
        // Channel 0 programmed to H=2/L=3 with a tick every cycle once running.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 5'b00001, 4'b0001};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 5'b11001, 4'b0001};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 5'b10110, 4'b0001};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 5'b10001, 4'b0000};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 5'b11001, 4'b0000};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 5'b10010, 4'b0000};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 5'b10010, 4'b0000};
        vt[10] = '{1'b0, 1'b1, 1'b1, 5'b10110, 4'b0000};
        vt[11] = '{1'b0, 1'b1, 1'b1, 5'b10001, 4'b0000};
        vt[12] = '{1'b0, 1'b1, 1'b1, 5'b11001, 4'b0000};
        vt[13] = '{1'b0, 1'b1, 1'b1, 5'b10010, 4'b0000};
        vt[14] = '{1'b0, 1'b1, 1'b1, 5'b10010, 4'b0000};
        vt[15] = '{1'b0, 1'b1, 1'b1, 5'b10110, 4'b0000};
        vt[16] = '{1'b0, 1'b1, 1'b1, 5'b10001, 4'b0000};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_bus", 32'(bus), 32'h08421);
        chk("reset_pend", 32'(pend), 32'h0);
        chk("reset_bus3", 32'(bus3), 32'h0421);
        rst_n = 1'b1;

        // Out-of-range channel on a 3-channel instance is dropped
        wr3 = 1'b1; ch3 = 2'd3;
        cyc();
        wr3 = 1'b0;
        chk("oor_ignored", 32'(pend3), 32'h0);
        wr3 = 1'b1; ch3 = 2'd2;
        cyc();
        wr3 = 1'b0;
        chk("inrange_pend", 32'(pend3), 32'h4);

        // Free-run with reload 3: tick every 4 cycles, first after RELOAD_VALUE+1
        rst_n = 1'b0; run = 1'b1; tick_reload = 31'd3;
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("freerun_c%0d", k), 32'(tick), 32'((k % 4) == 0));
        end

        // Duty table
        rst_n = 1'b0; run = 1'b0; tick_reload = 31'd0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cfg_wr = vt[i].wr; cfg_ch = 2'd0; cfg_hi = 8'd2; cfg_lo = 8'd3;
            run = vt[i].run;
            cyc();
            chk($sformatf("duty_tick_%0d", i), 32'(tick), 32'(vt[i].exp_tick));
            chk($sformatf("duty_bus0_%0d", i), 32'(bus[4:0]), 32'(vt[i].exp_bus0));
            chk($sformatf("duty_pend_%0d", i), 32'(pend), 32'(vt[i].exp_pend));
        end
        cfg_wr = 1'b0;

        // Deferred config on ch1 (H=4,L=1), others unaffected
        cfg_cycle(2'd1, 8'd4, 8'd1);
        chk("defer_pend_set", 32'(pend), 32'h2);
        chk("defer_ch1_c18", 32'(lvl(1)), 32'h0);
        cyc();
        chk("defer_pend_clr", 32'(pend), 32'h0);
        chk("defer_ch1_c19", 32'(lvl(1)), 32'h1);
        chk("defer_ch0_c19", 32'(lvl(0)), 32'h0);
        chk("defer_ch2_c19", 32'(lvl(2)), 32'h1);
        chk("defer_ch3_c19", 32'(lvl(3)), 32'h1);
        cyc();
        chk("defer_ch1_c20", 32'(lvl(1)), 32'h1);
        chk("defer_ch0_c20", 32'(lvl(0)), 32'h0);
        chk("defer_ch2_c20", 32'(lvl(2)), 32'h0);
        chk("defer_ch3_c20", 32'(lvl(3)), 32'h0);
        cfg_cycle(2'd1, 8'd1, 8'd1);
        chk("defer_ch1_c21", 32'(lvl(1)), 32'h1);
        chk("defer_pend_c21", 32'(pend), 32'h2);
        chk("defer_ch0_c21", 32'(lvl(0)), 32'h0);
        chk("defer_ch2_c21", 32'(lvl(2)), 32'h1);
        cyc();
        chk("defer_ch1_c22", 32'(lvl(1)), 32'h1);
        chk("defer_ch0_c22", 32'(lvl(0)), 32'h1);
        cyc();
        chk("defer_ch1_c23", 32'(lvl(1)), 32'h0);
        chk("defer_ch0_c23", 32'(lvl(0)), 32'h1);

        // Write in the transfer cycle: old shadow used, pending stays set
        cfg_cycle(2'd1, 8'd2, 8'd2);
        chk("xfer_ch1_c24", 32'(lvl(1)), 32'h1);
        chk("xfer_pend_c24", 32'(pend), 32'h2);
        cyc();
        chk("xfer_ch1_c25", 32'(lvl(1)), 32'h0);
        chk("xfer_pend_c25", 32'(pend), 32'h2);
        cyc();
        chk("xfer_ch1_c26", 32'(lvl(1)), 32'h1);
        chk("xfer_pend_c26", 32'(pend), 32'h0);

        // H=0 clamps to a 1-tick high on ch2 (L=2)
        cfg_cycle(2'd2, 8'd0, 8'd2);
        chk("clamp_ch2_c27", 32'(lvl(2)), 32'h1);
        chk("clamp_pend_c27", 32'(pend), 32'h4);
        chk("xfer_ch1_c27", 32'(lvl(1)), 32'h1);
        cyc();
        chk("clamp_ch2_c28", 32'(lvl(2)), 32'h0);
        chk("xfer_ch1_c28", 32'(lvl(1)), 32'h0);
        cyc();
        chk("clamp_ch2_c29", 32'(lvl(2)), 32'h1);
        chk("clamp_pend_c29", 32'(pend), 32'h0);
        chk("xfer_ch1_c29", 32'(lvl(1)), 32'h0);
        cyc();
        chk("clamp_ch2_c30", 32'(lvl(2)), 32'h0);
        chk("xfer_ch1_c30", 32'(lvl(1)), 32'h1);
        cyc();
        chk("clamp_ch2_c31", 32'(lvl(2)), 32'h0);
        cyc();
        chk("clamp_ch2_c32", 32'(lvl(2)), 32'h1);

        // Single-step: three edges, each held 5 cycles
        rst_n = 1'b0; run = 1'b0; step = 1'b0; tick_reload = 31'd3;
        cyc();
        rst_n = 1'b1;
        n_ticks = 0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            for (int j = 0; j < 5; j++) begin
                cyc();
                if (tick) n_ticks++;
                chk($sformatf("step%0d_hi_c%0d", s, j), 32'(tick), 32'(j == 0));
            end
            step = 1'b0;
            for (int j = 0; j < 5; j++) begin
                cyc();
                if (tick) n_ticks++;
                chk($sformatf("step%0d_lo_c%0d", s, j), 32'(tick), 32'h0);
            end
        end
        chk("step_count", 32'(n_ticks), 32'd3);

        // Counter untouched by steps; step ignored while running; run halt/resume
        run = 1'b1; step = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            chk($sformatf("resume_c%0d", j), 32'(tick), 32'(j == 4));
        end
        cyc();
        chk("prehalt_c5", 32'(tick), 32'h0);
        cyc();
        chk("prehalt_c6", 32'(tick), 32'h0);
        run = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk($sformatf("halt_c%0d", j), 32'(tick), 32'h0);
        end
        run = 1'b1; step = 1'b0;
        cyc();
        chk("unhalt_c1", 32'(tick), 32'h0);
        cyc();
        chk("unhalt_c2", 32'(tick), 32'h1);

        // Reset mid-run while channels are LOW with a pending write
        cfg_cycle(2'd3, 8'd5, 8'd5);
        chk("prerst_ch0_low", 32'(lvl(0)), 32'h0);
        chk("prerst_pend", 32'(pend), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("midrst_bus", 32'(bus), 32'h08421);
        chk("midrst_tick", 32'(tick), 32'h0);
        chk("midrst_pend", 32'(pend), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("postrst_ch0", 32'(lvl(0)), 32'h1);
        chk("postrst_tick", 32'(tick), 32'h0);
        chk("postrst_pend", 32'(pend), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
